// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC packet constants and spike arbiter state type
package noc_pkg;

    localparam int PACKET_W   = 32;
    localparam int FLIT_W     = 4;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at ptr, ptr+1, ... mod NUM_REQ
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // One extra bit holds ptr+k before the wrap, so non-power-of-two counts work.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!any_req && req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_inject_arbiter.sv
// rtl/spike_inject_arbiter.sv - shares one router local port among neuron cores; ARB_DROP_CNT_EN adds per-neuron drop counters
module spike_inject_arbiter #(
    parameter int NUM_NEURONS = 4,
    parameter int PACKET_W    = noc_pkg::PACKET_W
) (
    input  logic                            clk,
    input  logic                            rt_reset,
    input  logic [NUM_NEURONS-1:0]          spike_valid,
    input  logic [NUM_NEURONS*PACKET_W-1:0] spike_packet,
    output logic [NUM_NEURONS-1:0]          hold_busy,
    output logic [PACKET_W-1:0]             local_in,
    output logic                            write_en_local,
    input  logic                            local_full,
    output logic                            drop_any
`ifdef ARB_DROP_CNT_EN
    ,
    output logic [NUM_NEURONS*noc_pkg::DROP_CNT_W-1:0] drop_count
`endif
);

    import noc_pkg::*;

    localparam int IDX_W = $clog2(NUM_NEURONS);

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     next_ptr;
    logic [PACKET_W-1:0]  hold_data [NUM_NEURONS];

    logic                   xfer;
    logic [NUM_NEURONS-1:0] rel;
    logic [NUM_NEURONS-1:0] cap;
    logic [NUM_NEURONS-1:0] drop;
    logic [NUM_NEURONS-1:0] pick_req;
    logic [IDX_W-1:0]       pick_ptr;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    assign xfer     = (state == ARB_SEND) && write_en_local && !local_full;
    assign next_ptr = (grant == IDX_W'(NUM_NEURONS-1)) ? '0 : grant + 1'b1;

    // In SEND the picker looks ahead to the slot that follows a completing
    // transfer; same-edge captures are not visible yet and wait for the next pick.
    always_comb begin
        rel = '0;
        if (xfer) begin
            rel[grant] = 1'b1;
        end
        cap  = spike_valid & (~hold_busy | rel);
        drop = spike_valid & hold_busy & ~rel;
        if (state == ARB_SEND) begin
            pick_req = hold_busy & ~rel;
            pick_ptr = next_ptr;
        end else begin
            pick_req = hold_busy;
            pick_ptr = ptr;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_NEURONS),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (pick_req),
        .ptr     (pick_ptr),
        .grant   (pick_idx),
        .any_req (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rt_reset) begin
            hold_busy <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (cap[i]) begin
                    hold_busy[i] <= 1'b1;
                    hold_data[i] <= spike_packet[i*PACKET_W +: PACKET_W];
                end else if (rel[i]) begin
                    hold_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rt_reset) begin
            drop_any <= 1'b0;
        end else if (|drop) begin
            drop_any <= 1'b1;
        end
    end

    // Under backpressure nothing here changes, so local_in and the grant hold.
    always_ff @(posedge clk) begin
        if (rt_reset) begin
            state          <= ARB_IDLE;
            ptr            <= '0;
            grant          <= '0;
            local_in       <= '0;
            write_en_local <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        local_in       <= hold_data[pick_idx];
                        grant          <= pick_idx;
                        write_en_local <= 1'b1;
                        state          <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    if (xfer) begin
                        ptr <= next_ptr;
                        if (pick_any) begin
                            local_in <= hold_data[pick_idx];
                            grant    <= pick_idx;
                        end else begin
                            local_in       <= '0;
                            write_en_local <= 1'b0;
                            state          <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    write_en_local <= 1'b0;
                    state          <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rt_reset) begin
            drop_count <= '0;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (drop[i] && (drop_count[i*DROP_CNT_W +: DROP_CNT_W] != {DROP_CNT_W{1'b1}})) begin
                    drop_count[i*DROP_CNT_W +: DROP_CNT_W] <= drop_count[i*DROP_CNT_W +: DROP_CNT_W] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_inject_arbiter.sv
// tb/tb_spike_inject_arbiter.sv - self-checking bench for spike_inject_arbiter
module tb_spike_inject_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rt_reset;
    logic [N-1:0]   spike_valid;
    logic [N*W-1:0] spike_packet;
    logic [N-1:0]   hold_busy;
    logic [W-1:0]   local_in;
    logic           write_en_local;
    logic           local_full;
    logic           drop_any;
`ifdef ARB_DROP_CNT_EN
    logic [N*16-1:0] drop_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q [$];

    typedef struct {
        logic         full;
        logic [N-1:0] sv;
        logic [W-1:0] pkt;
        logic         push;
        logic [N-1:0] busy;
        logic         we;
        logic [W-1:0] din;
        logic         drop;
    } vec_t;

    vec_t vt [13];

    always #5 clk = ~clk;

    spike_inject_arbiter #(
        .NUM_NEURONS (N),
        .PACKET_W    (W)
    ) dut (
        .clk            (clk),
        .rt_reset       (rt_reset),
        .spike_valid    (spike_valid),
        .spike_packet   (spike_packet),
        .hold_busy      (hold_busy),
        .local_in       (local_in),
        .write_en_local (write_en_local),
        .local_full     (local_full),
        .drop_any       (drop_any)
`ifdef ARB_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a transfer completes at the next edge when write_en_local=1 and local_full=0.
    always @(negedge clk) begin
        if (!rt_reset && write_en_local === 1'b1 && local_full === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: got %h want none", local_in);
            end else begin
                chk("xfer_data", local_in, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        //        full  sv       pkt            push  busy     we    din            drop
        vt[0]  = '{1'b0, 4'b0100, 32'hA5A5_0002, 1'b1, 4'b0100, 1'b0, 32'h0,         1'b0};
        vt[1]  = '{1'b0, 4'b0000, 32'h0,         1'b0, 4'b0100, 1'b1, 32'hA5A5_0002, 1'b0};
        vt[2]  = '{1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0,         1'b0};
        vt[3]  = '{1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0,         1'b0};
        vt[4]  = '{1'b0, 4'b0001, 32'h1111_0000, 1'b1, 4'b0001, 1'b0, 32'h0,         1'b0};
        vt[5]  = '{1'b1, 4'b0000, 32'h0,         1'b0, 4'b0001, 1'b1, 32'h1111_0000, 1'b0};
        vt[6]  = '{1'b1, 4'b0010, 32'h2222_0001, 1'b1, 4'b0011, 1'b1, 32'h1111_0000, 1'b0};
        vt[7]  = '{1'b1, 4'b0000, 32'h0,         1'b0, 4'b0011, 1'b1, 32'h1111_0000, 1'b0};
        vt[8]  = '{1'b1, 4'b0010, 32'hDEAD_0001, 1'b0, 4'b0011, 1'b1, 32'h1111_0000, 1'b1};
        vt[9]  = '{1'b1, 4'b0000, 32'h0,         1'b0, 4'b0011, 1'b1, 32'h1111_0000, 1'b1};
        vt[10] = '{1'b1, 4'b0000, 32'h0,         1'b0, 4'b0011, 1'b1, 32'h1111_0000, 1'b1};
        vt[11] = '{1'b0, 4'b0000, 32'h0,         1'b0, 4'b0010, 1'b1, 32'h2222_0001, 1'b1};
        vt[12] = '{1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0,         1'b1};

        rt_reset     = 1'b1;
        spike_valid  = '0;
        spike_packet = '0;
        local_full   = 1'b0;
        tick();
        tick();
        chk("rst_we", W'(write_en_local), W'(1'b0));
        chk("rst_local_in", local_in, 32'h0);
        chk("rst_busy", W'(hold_busy), W'(4'b0000));
        chk("rst_drop_any", W'(drop_any), W'(1'b0));
`ifdef ARB_DROP_CNT_EN
        chk("rst_drop_count_lo", drop_count[31:0], 32'h0);
        chk("rst_drop_count_hi", drop_count[63:32], 32'h0);
`endif
        rt_reset = 1'b0;

        // Single spike, backpressure and drop, one row per cycle
        for (int k = 0; k < 13; k++) begin
            local_full   = vt[k].full;
            spike_valid  = vt[k].sv;
            spike_packet = {N{vt[k].pkt}};
            if (vt[k].push) begin
                exp_q.push_back(vt[k].pkt);
            end
            tick();
            spike_valid = '0;
            chk($sformatf("vec%0d_busy", k), W'(hold_busy), W'(vt[k].busy));
            chk($sformatf("vec%0d_we", k), W'(write_en_local), W'(vt[k].we));
            chk($sformatf("vec%0d_drop_any", k), W'(drop_any), W'(vt[k].drop));
            if (vt[k].we) begin
                chk($sformatf("vec%0d_local_in", k), local_in, vt[k].din);
            end
        end
`ifdef ARB_DROP_CNT_EN
        chk("drop_count_lo", drop_count[31:0], 32'h0001_0000);
        chk("drop_count_hi", drop_count[63:32], 32'h0);
`endif

        // Round robin from a fresh pointer
        rt_reset = 1'b1;
        tick();
        rt_reset = 1'b0;
        chk("rr_rst_drop_any", W'(drop_any), W'(1'b0));
        spike_packet = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        spike_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'hC0DE_0000 + W'(i));
        end
        tick();
        spike_valid = '0;
        chk("rr_busy_all", W'(hold_busy), W'(4'b1111));
        chk("rr_we_pre", W'(write_en_local), W'(1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_we_%0d", i), W'(write_en_local), W'(1'b1));
            chk($sformatf("rr_order_%0d", i), local_in, 32'hC0DE_0000 + W'(i));
        end
        tick();
        chk("rr_we_done", W'(write_en_local), W'(1'b0));
        chk("rr_busy_done", W'(hold_busy), W'(4'b0000));

        spike_packet = {32'hBEEF_0003, 32'h0, 32'hBEEF_0001, 32'h0};
        spike_valid  = 4'b1010;
        exp_q.push_back(32'hBEEF_0001);
        exp_q.push_back(32'hBEEF_0003);
        tick();
        spike_valid = '0;
        tick();
        chk("rr2_first", local_in, 32'hBEEF_0001);
        tick();
        chk("rr2_second", local_in, 32'hBEEF_0003);
        tick();
        chk("rr2_we_done", W'(write_en_local), W'(1'b0));

        // Same-edge refill of slot 0
        spike_packet = {96'h0, 32'hF00D_0001};
        spike_valid  = 4'b0001;
        exp_q.push_back(32'hF00D_0001);
        tick();
        spike_valid = '0;
        chk("refill_busy0", W'(hold_busy), W'(4'b0001));
        tick();
        chk("refill_first", local_in, 32'hF00D_0001);
        spike_packet = {96'h0, 32'hF00D_0002};
        spike_valid  = 4'b0001;
        exp_q.push_back(32'hF00D_0002);
        tick();
        spike_valid = '0;
        chk("refill_busy_kept", W'(hold_busy), W'(4'b0001));
        chk("refill_we_gap", W'(write_en_local), W'(1'b0));
        tick();
        chk("refill_we_second", W'(write_en_local), W'(1'b1));
        chk("refill_second", local_in, 32'hF00D_0002);
        tick();
        chk("refill_busy_done", W'(hold_busy), W'(4'b0000));

        // Reset in the middle of a blocked SEND with three slots held
        local_full   = 1'b1;
        spike_packet = {32'h0, 32'h5EED_0002, 32'h5EED_0001, 32'h5EED_0000};
        spike_valid  = 4'b0111;
        tick();
        spike_valid = '0;
        chk("mrst_busy", W'(hold_busy), W'(4'b0111));
        tick();
        chk("mrst_we", W'(write_en_local), W'(1'b1));
        chk("mrst_grant_from_ptr1", local_in, 32'h5EED_0001);
        tick();
        rt_reset = 1'b1;
        tick();
        chk("mrst_out_we", W'(write_en_local), W'(1'b0));
        chk("mrst_out_local_in", local_in, 32'h0);
        chk("mrst_out_busy", W'(hold_busy), W'(4'b0000));
        chk("mrst_out_drop_any", W'(drop_any), W'(1'b0));
        rt_reset   = 1'b0;
        local_full = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (write_en_local !== 1'b0) begin
                seen++;
            end
        end
        chk("mrst_quiet", W'(seen), W'(0));

        chk("scoreboard_empty", W'(exp_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_inject_arbiter.md
# spike_inject_arbiter

Shares one router local injection port between NUM_NEURONS neuron cores. Each neuron's 32-bit spike packet is captured into a one-entry holding register. A round-robin scheduler presents the packets one at a time on the router's local_in / write_en_local pair and honours local_full backpressure. It sits between a cluster of Neuron instances and the router's local port, in place of the direct neuron-to-router connection.

## Interface
- NUM_NEURONS, 4, number of requesting neurons (2..16)
- PACKET_W, 32, spike packet width
- clk  in  1  single clock for the block; neurons and router local port run on it
- rt_reset  in  1  synchronous, active-high reset
- spike_valid  in  NUM_NEURONS  bit i = neuron i outSpike, one-cycle pulse per packet
- spike_packet  in  NUM_NEURONS*PACKET_W  neuron i SpikePacket in bits [i*PACKET_W +: PACKET_W]
- hold_busy  out  NUM_NEURONS  bit i = holding register i occupied
- local_in  out  PACKET_W  packet to router local port
- write_en_local  out  1  packet on local_in valid
- local_full  in  1  router local input FIFO full
- drop_any  out  1  sticky; set on any dropped spike, cleared only by rt_reset
- drop_count  out  NUM_NEURONS*16  per-neuron drop counters (only with ARB_DROP_CNT_EN)

## Operation
- Holding register i captures spike_packet[i] on an edge where spike_valid[i]=1 and register i is free, or is being released on that same edge. Release-and-capture on one edge leaves the register occupied with the new packet.
- spike_valid[i]=1 while register i is occupied and not releasing: the packet is dropped, drop_any is set, and the drop counter increments.
- Round-robin pointer ptr (log2 NUM_NEURONS bits, reset 0):
  - Grant goes to the first occupied register at index ptr, ptr+1, … mod NUM_NEURONS.
  - After a completed transfer from index g, ptr = (g+1) mod NUM_NEURONS.
- FSM states:
  - IDLE: write_en_local=0. If any register is occupied, register the granted packet onto local_in, set write_en_local=1, go to SEND.
  - SEND: a transfer completes on an edge with write_en_local=1 and local_full=0. On completion, release the granted register and advance ptr.
    - If another register is occupied after the release (excluding a same-edge capture into the released slot), load it immediately and stay in SEND.
    - Otherwise go to IDLE.
  - SEND with local_full=1: local_in and write_en_local are held stable; the grant is not re-evaluated.
- A capture into the currently granted register is impossible, because it is occupied and not releasing.

## Timing
- Reset values: write_en_local=0, local_in=0, hold_busy=0, drop_any=0, drop_count=0, ptr=0, state=IDLE.
- Latency with the router idle: spike_valid high in cycle 0 -> hold_busy in cycle 1 -> write_en_local=1 in cycle 2.
- Throughput: one packet per cycle while local_full=0.
- Worst-case wait for any occupied register: NUM_NEURONS-1 transfers.
- rt_reset mid-transfer: in-flight and held packets are discarded and all outputs return to reset values on the next edge. No partial handshake survives.
- local_full rising in the same cycle write_en_local rises: no transfer that cycle; hold and retry.

## Configuration
- ARB_DROP_CNT_EN defined:
  - drop_count port exists.
  - Each 16-bit counter increments by 1 per dropped spike and saturates at 16'hFFFF.
- ARB_DROP_CNT_EN undefined:
  - drop_count port and counters are absent.
  - Drops are reported only through drop_any.

## Structure
- Shared package noc_pkg:
  - PACKET_W=32, FLIT_W=4
  - arbiter state enum {ARB_IDLE, ARB_SEND}
  - DROP_CNT_W=16
- Sub-module rr_pick: combinational round-robin priority picker. Inputs: request vector and ptr. Outputs: grant index and any_req.

## Test plan
- Single spike: neuron 2 fires 32'hA5A5_0002 in cycle 0, local_full=0 -> write_en_local=1 with local_in=32'hA5A5_0002 in cycle 2 only; hold_busy[2] clears after that edge.
- Round-robin: neurons 0–3 all fire in the same cycle -> transfers in order 0,1,2,3 on consecutive cycles. Then neurons 1 and 3 fire -> order 1,3 (ptr=0 after 3 wraps to 0, first occupied is 1).
- Backpressure: local_full=1 for 5 cycles while SEND -> local_in is constant, write_en_local=1 throughout; transfer completes on the first edge with local_full=0.
- Drop: neuron 1 fires twice while blocked by local_full=1 -> second packet is lost, drop_any=1, drop_count[1]=1 (with ARB_DROP_CNT_EN). The first packet is delivered intact.
- Same-edge refill: neuron 0 fires on the exact edge its register releases -> new packet is held, hold_busy[0] stays 1, and it is delivered in a later cycle.
- Reset: assert rt_reset during SEND with 3 registers occupied -> next cycle all outputs are 0; no packets are emitted after reset deasserts until new spikes arrive.
